regfile_port_arbiter: RTL and testbench

- Shares the register file's single write port and its second read port between the pipeline and a host/debug requester, such as the FPGA loader or a UART monitor.
- The pipeline always has priority. The host is served in idle slots.
- A starvation counter forces a one-cycle pipeline stall when the host has waited MAX_WAIT cycles.
- Sits between the decode/writeback stages and the register file.

---
 rtl/regfile_arb_pkg.sv | 18 +
 rtl/regfile_arb_starve_cnt.sv | 43 ++++
 rtl/regfile_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arb_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_WAIT  = 2'd1,
      ARB_FORCE = 2'd2
   } arb_state_t;

   function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
      return addr == ZERO_REG;
   endfunction

endpackage

// File: rtl/regfile_arb_starve_cnt.sv
// Starvation counter: counts consecutive refused host cycles and flags when
// one more refusal reaches the forced-grant threshold.
module regfile_arb_starve_cnt #(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   output logic limit_o
);

   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(MAX_WAIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle without a refusal restarts the count.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         if (cnt_q != SAT_VAL) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign limit_o = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= LIMIT;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and read port 2 between pipeline and host.
// Optional macro REGARB_STALL_COUNT_EN adds the forced_stall_cnt output.
module regfile_port_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef REGARB_STALL_COUNT_EN
   output logic [15:0]       forced_stall_cnt,
`endif
   input  logic              pipe_we,
   input  logic [REG_AW-1:0] pipe_waddr,
   input  logic [REG_DW-1:0] pipe_wdata,
   input  logic [REG_AW-1:0] pipe_raddr2,
   input  logic              pipe_rs2_used,
   output logic              pipe_stall,
   input  logic              host_req_valid,
   input  logic              host_req_write,
   input  logic [REG_AW-1:0] host_req_addr,
   input  logic [REG_DW-1:0] host_req_wdata,
   output logic              host_req_ready,
   output logic              host_rsp_valid,
   output logic [REG_DW-1:0] host_rsp_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [REG_DW-1:0] rf_wdata,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [REG_DW-1:0] rf_rdata2
);

   arb_state_t        state_q, state_d;
   logic              force_s;
   logic              host_wr_gnt_s, host_rd_gnt_s, host_gnt_s;
   logic              refuse_s, limit_s;
   logic              rsp_valid_q, rsp_valid_d;
   logic [REG_DW-1:0] rsp_rdata_q, rsp_rdata_d;

   assign force_s    = (state_q == ARB_FORCE);
   assign host_gnt_s = host_wr_gnt_s | host_rd_gnt_s;
   assign refuse_s   = !rst && host_req_valid && !host_gnt_s && !force_s;

   // Host grant: pipeline keeps priority except in a forced slot; nothing is granted in reset.
   always_comb begin
      host_wr_gnt_s = 1'b0;
      host_rd_gnt_s = 1'b0;
      if (!rst && host_req_valid) begin
         if (host_req_write) begin
            host_wr_gnt_s = force_s || !pipe_we || is_zero_reg(pipe_waddr);
         end else begin
            host_rd_gnt_s = force_s || !pipe_rs2_used;
         end
      end else begin
         host_wr_gnt_s = 1'b0;
         host_rd_gnt_s = 1'b0;
      end
   end

   // Register-file port steering.
   always_comb begin
      rf_we     = 1'b0;
      rf_waddr  = pipe_waddr;
      rf_wdata  = pipe_wdata;
      rf_raddr2 = pipe_raddr2;
      if (host_wr_gnt_s) begin
         rf_we    = !is_zero_reg(host_req_addr);
         rf_waddr = host_req_addr;
         rf_wdata = host_req_wdata;
      end else begin
         rf_we = !rst && !force_s && pipe_we && !is_zero_reg(pipe_waddr);
      end
      if (host_rd_gnt_s) begin
         rf_raddr2 = host_req_addr;
      end else begin
         rf_raddr2 = pipe_raddr2;
      end
   end

   assign host_req_ready = host_gnt_s;
   assign pipe_stall     = force_s && !rst;

   regfile_arb_starve_cnt #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_starve_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (refuse_s),
      .limit_o (limit_s)
   );

   // Next-state logic; a forced slot always returns to IDLE so stalls never repeat back to back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE, ARB_WAIT: begin
            if (refuse_s) begin
               state_d = limit_s ? ARB_FORCE : ARB_WAIT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_FORCE: state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   // Read response capture, with bypass of a same-cycle pipeline write.
   always_comb begin
      rsp_valid_d = host_rd_gnt_s;
      rsp_rdata_d = rsp_rdata_q;
      if (host_rd_gnt_s) begin
         if (is_zero_reg(host_req_addr)) begin
            rsp_rdata_d = {REG_DW{1'b0}};
         end else if (pipe_we && (pipe_waddr == host_req_addr)) begin
            rsp_rdata_d = pipe_wdata;
         end else begin
            rsp_rdata_d = rf_rdata2;
         end
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   // State and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {REG_DW{1'b0}};
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign host_rsp_valid = rsp_valid_q;
   assign host_rsp_rdata = rsp_rdata_q;

`ifdef REGARB_STALL_COUNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of forced stall cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (force_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign forced_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_regfile_port_arbiter;

   localparam int MAX_WAIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic [4:0]  pipe_raddr2;
   logic        pipe_rs2_used;
   logic        pipe_stall;
   logic        host_req_valid;
   logic        host_req_write;
   logic [4:0]  host_req_addr;
   logic [31:0] host_req_wdata;
   logic        host_req_ready;
   logic        host_rsp_valid;
   logic [31:0] host_rsp_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata2;
`ifdef REGARB_STALL_COUNT_EN
   logic [15:0] forced_stall_cnt;
`endif

   logic [31:0] model_rf [32];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // The register file is the bench's own model array.
   assign rf_rdata2 = model_rf[rf_raddr2];

   regfile_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef REGARB_STALL_COUNT_EN
      .forced_stall_cnt (forced_stall_cnt),
`endif
      .pipe_we        (pipe_we),
      .pipe_waddr     (pipe_waddr),
      .pipe_wdata     (pipe_wdata),
      .pipe_raddr2    (pipe_raddr2),
      .pipe_rs2_used  (pipe_rs2_used),
      .pipe_stall     (pipe_stall),
      .host_req_valid (host_req_valid),
      .host_req_write (host_req_write),
      .host_req_addr  (host_req_addr),
      .host_req_wdata (host_req_wdata),
      .host_req_ready (host_req_ready),
      .host_rsp_valid (host_rsp_valid),
      .host_rsp_rdata (host_rsp_rdata),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .rf_raddr2      (rf_raddr2),
      .rf_rdata2      (rf_rdata2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pipe_we = 1'b0; pipe_rs2_used = 1'b0;
      host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 5'd5; host_req_wdata = 32'h0BAD_0BAD;
      #2;
      checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", host_req_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
      tick();
      checks++; if (host_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", host_rsp_valid); end
      checks++; if (host_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", host_rsp_rdata); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
`ifdef REGARB_STALL_COUNT_EN
      checks++; if (forced_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", forced_stall_cnt); end
`endif
      rst = 1'b0; host_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_idle_write();
      pipe_we = 1'b0;
      host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 5'd5; host_req_wdata = 32'hDEAD_BEEF;
      #2;
      checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b expected 1", host_req_ready); end
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL idle_wr_we: got %b expected 1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL idle_wr_addr: got %0d expected 5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_wr_data: got %h expected deadbeef", rf_wdata); end
      tick();
      host_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_conflict();
      pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3333_3333;
      host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 5'd7; host_req_wdata = 32'h7777_7777;
      for (int c = 0; c <= 8; c++) begin
         if (c == 8) host_req_valid = 1'b0;
         #2;
         if (c < 7) begin
            checks++; if (host_req_ready !== 1'b0 || pipe_stall !== 1'b0 || rf_waddr !== 5'd3 || rf_we !== 1'b1)
               begin errors++; $display("FAIL conflict_wait c=%0d: got rdy=%b stall=%b we=%b wa=%0d expected 0 0 1 3", c, host_req_ready, pipe_stall, rf_we, rf_waddr); end
         end else if (c == 7) begin
            checks++; if (host_req_ready !== 1'b1 || pipe_stall !== 1'b1 || rf_waddr !== 5'd7 || rf_we !== 1'b1 || rf_wdata !== 32'h7777_7777)
               begin errors++; $display("FAIL conflict_force: got rdy=%b stall=%b we=%b wa=%0d wd=%h expected 1 1 1 7 77777777", host_req_ready, pipe_stall, rf_we, rf_waddr, rf_wdata); end
         end else begin
            checks++; if (pipe_stall !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333_3333 || rf_we !== 1'b1)
               begin errors++; $display("FAIL conflict_after: got stall=%b we=%b wa=%0d expected 0 1 3", pipe_stall, rf_we, rf_waddr); end
`ifdef REGARB_STALL_COUNT_EN
            checks++; if (forced_stall_cnt !== 16'd1) begin errors++; $display("FAIL conflict_stall_cnt: got %0d expected 1", forced_stall_cnt); end
`endif
         end
         tick();
      end
      pipe_we = 1'b0;
      tick();
   endtask

   task automatic test_idle_read();
      model_rf[5] = 32'h0000_1234;
      pipe_we = 1'b0; pipe_rs2_used = 1'b0; pipe_raddr2 = 5'd12;
      host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 5'd5;
      #2;
      checks++; if (host_req_ready !== 1'b1 || rf_raddr2 !== 5'd5) begin errors++; $display("FAIL idle_rd_grant: got rdy=%b ra=%0d expected 1 5", host_req_ready, rf_raddr2); end
      tick();
      host_req_valid = 1'b0;
      #2;
      checks++; if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== 32'h0000_1234) begin errors++; $display("FAIL idle_rd_rsp: got v=%b d=%h expected 1 00001234", host_rsp_valid, host_rsp_rdata); end
      tick();
      checks++; if (host_rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_pulse: got %b expected 0", host_rsp_valid); end
   endtask

   task automatic test_bypass();
      model_rf[9] = 32'h1111_9999;
      pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'hCAFE_0001; pipe_rs2_used = 1'b0;
      host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 5'd9;
      #2;
      checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", host_req_ready); end
      tick();
      host_req_valid = 1'b0; pipe_we = 1'b0;
      #2;
      checks++; if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL bypass_rsp: got v=%b d=%h expected 1 cafe0001", host_rsp_valid, host_rsp_rdata); end
      tick();
   endtask

   task automatic test_x0();
      model_rf[0] = 32'h5555_5555;
      pipe_we = 1'b0; pipe_rs2_used = 1'b0;
      host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 5'd0; host_req_wdata = 32'hFFFF_FFFF;
      #2;
      checks++; if (host_req_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL x0_write: got rdy=%b we=%b expected 1 0", host_req_ready, rf_we); end
      tick();
      host_req_write = 1'b0;
      tick();
      host_req_valid = 1'b0;
      pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hAAAA_AAAA;
      #2;
      checks++; if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== 32'h0) begin errors++; $display("FAIL x0_read: got v=%b d=%h expected 1 0", host_rsp_valid, host_rsp_rdata); end
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL x0_pipe_write: got we=%b wa=%0d expected 0 0", rf_we, rf_waddr); end
      tick();
      pipe_we = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3333_3333;
      host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 5'd7; host_req_wdata = 32'h7070_7070;
      for (int c = 0; c < 4; c++) tick();
      rst = 1'b1;
      #2;
      checks++; if (host_req_ready !== 1'b0 || rf_we !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_wait_cycle: got rdy=%b we=%b stall=%b expected 0 0 0", host_req_ready, rf_we, pipe_stall); end
      tick();
      rst = 1'b0;
      #2;
      checks++; if (host_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_rsp: got %b expected 0", host_rsp_valid); end
`ifdef REGARB_STALL_COUNT_EN
      checks++; if (forced_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_wait_stall_cnt: got %0d expected 0", forced_stall_cnt); end
`endif
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) #2;
         if (c < 7) begin
            checks++; if (host_req_ready !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_rearb c=%0d: got rdy=%b stall=%b expected 0 0", c, host_req_ready, pipe_stall); end
         end else begin
            checks++; if (host_req_ready !== 1'b1 || pipe_stall !== 1'b1) begin errors++; $display("FAIL rst_rearb_force: got rdy=%b stall=%b expected 1 1", host_req_ready, pipe_stall); end
         end
         tick();
      end
      host_req_valid = 1'b0; pipe_we = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int          refused;
      int          stalls;
      logic        exp_rv, exp_stall, exp_wg, exp_rg, exp_we;
      logic [31:0] exp_rd, exp_wd;
      logic [4:0]  exp_wa, exp_ra;
      rst = 1'b1; host_req_valid = 1'b0;
      tick();
      rst = 1'b0;
      refused = 0; stalls = 0; exp_rv = 1'b0; exp_rd = 32'h0;
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 99) == 0);
         pipe_we       = ($urandom_range(0, 3) != 0);
         pipe_waddr    = 5'($urandom_range(0, 7));
         pipe_wdata    = $urandom;
         pipe_raddr2   = 5'($urandom_range(0, 31));
         pipe_rs2_used = ($urandom_range(0, 3) != 0);
         if (!host_req_valid && $urandom_range(0, 2) == 0) begin
            host_req_valid = 1'b1;
            host_req_write = 1'($urandom_range(0, 1));
            host_req_addr  = 5'($urandom_range(0, 7));
            host_req_wdata = $urandom;
         end
         #2;
         exp_stall = !rst && (refused == MAX_WAIT - 1);
         exp_wg = !rst && host_req_valid && host_req_write && (exp_stall || !pipe_we || pipe_waddr == 5'd0);
         exp_rg = !rst && host_req_valid && !host_req_write && (exp_stall || !pipe_rs2_used);
         exp_we = exp_wg ? (host_req_addr != 5'd0) : (!rst && !exp_stall && pipe_we && pipe_waddr != 5'd0);
         exp_wa = exp_wg ? host_req_addr : pipe_waddr;
         exp_wd = exp_wg ? host_req_wdata : pipe_wdata;
         exp_ra = exp_rg ? host_req_addr : pipe_raddr2;
         if (exp_stall) stalls++;
         checks++; if (host_req_ready !== (exp_wg | exp_rg)) begin errors++; $display("FAIL rnd_ready n=%0d: got %b expected %b", n, host_req_ready, exp_wg | exp_rg); end
         checks++; if (pipe_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d: got %b expected %b", n, pipe_stall, exp_stall); end
         checks++; if (rf_we !== exp_we || rf_waddr !== exp_wa || rf_wdata !== exp_wd)
            begin errors++; $display("FAIL rnd_wport n=%0d: got %b/%0d/%h expected %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, exp_we, exp_wa, exp_wd); end
         checks++; if (rf_raddr2 !== exp_ra) begin errors++; $display("FAIL rnd_raddr2 n=%0d: got %0d expected %0d", n, rf_raddr2, exp_ra); end
         checks++; if (host_rsp_valid !== exp_rv || host_rsp_rdata !== exp_rd)
            begin errors++; $display("FAIL rnd_rsp n=%0d: got %b/%h expected %b/%h", n, host_rsp_valid, host_rsp_rdata, exp_rv, exp_rd); end
         if (rst) begin
            exp_rv = 1'b0; exp_rd = 32'h0; refused = 0;
         end else begin
            exp_rv = exp_rg;
            if (exp_rg) begin
               if (host_req_addr == 5'd0) exp_rd = 32'h0;
               else if (pipe_we && pipe_waddr == host_req_addr) exp_rd = pipe_wdata;
               else exp_rd = model_rf[host_req_addr];
            end
            refused = (host_req_valid && !(exp_wg || exp_rg)) ? refused + 1 : 0;
         end
         tick();
         if (exp_we) model_rf[exp_wa] = exp_wd;
         if (exp_wg || exp_rg) host_req_valid = 1'b0;
      end
      checks++; if (stalls == 0) begin errors++; $display("FAIL rnd_stall_coverage: got %0d forced stalls expected >0", stalls); end
      rst = 1'b0; host_req_valid = 1'b0; pipe_we = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0101_0101 * i + 32'h00C0_FFEE;
      rst = 1'b1; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'h0;
      pipe_raddr2 = 5'd0; pipe_rs2_used = 1'b0;
      host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = 5'd0; host_req_wdata = 32'h0;
      tick();
      test_reset();
      test_idle_write();
      test_conflict();
      test_idle_read();
      test_bypass();
      test_x0();
      test_reset_in_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
